// File: rtl/led_sweep_engine.sv
// led_sweep_engine: LED pattern generator with four animations, a 4-level step rate,
// pause and a step-tick output. Optional fading comet tail in modes 0/1 when the
// TRAIL_EN macro is defined; the default build has no tail and no PWM counter.
module led_sweep_engine #(
  parameter int unsigned N_LEDS   = 18,
  parameter int unsigned DIV_BASE = 25_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET_N,
  input  logic [1:0]                  MODE,
  input  logic [1:0]                  SPEED,
  input  logic                        PAUSE,
  output logic [N_LEDS-1:0]           LEDR,
  output logic [$clog2(N_LEDS)-1:0]   POS,
  output logic                        STEP_TICK
);

  localparam int unsigned POS_W = $clog2(N_LEDS);
  localparam int unsigned HALF  = (N_LEDS + 1) / 2;
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(N_LEDS - 1);
  localparam logic [POS_W-1:0] CONV_LAST = POS_W'(HALF - 1);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_CONV   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  dir_e              dir_q, dir_d;
  mode_e             mode_q, mode_in;
  logic [N_LEDS-1:0] led_q, led_d;
  logic              tick_q, tick_d;
  logic [31:0]       per_full;
  logic [CNT_W-1:0]  per_m1;

  assign mode_in = mode_e'(MODE);

  // Step period minus one: DIV_BASE >> SPEED, clamped to a period of at least one clock
  always_comb begin
    per_full = 32'(DIV_BASE) >> SPEED;
    if (per_full == 32'd0) per_full = 32'd1;
    per_m1 = CNT_W'(per_full - 32'd1);
  end

  // Divider, head position and direction; a mode change restarts everything even when paused
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    tick_d = 1'b0;
    if (mode_in != mode_q) begin
      cnt_d = '0;
      pos_d = '0;
      dir_d = DIR_LEFT;
    end else if (!PAUSE) begin
      if (cnt_q >= per_m1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        case (mode_q)
          MODE_WRAP: begin
            dir_d = DIR_LEFT;
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
          end
          MODE_CONV: begin
            dir_d = DIR_LEFT;
            pos_d = (pos_q == CONV_LAST) ? '0 : pos_q + POS_W'(1);
          end
          default: begin
            // Bounce and bar: dwell one step at each end while the direction flips
            if (dir_q == DIR_LEFT) begin
              if (pos_q == POS_LAST) dir_d = DIR_RIGHT;
              else                   pos_d = pos_q + POS_W'(1);
            end else begin
              if (pos_q == '0) dir_d = DIR_LEFT;
              else             pos_d = pos_q - POS_W'(1);
            end
          end
        endcase
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef TRAIL_EN
  logic [2:0]       pwm_q;
  logic [POS_W-1:0] b1_idx, b2_idx;
  logic             b1_en, b2_en;

  // Tail positions one and two steps behind the head (opposite the direction of travel)
  always_comb begin
    b1_idx = pos_d - POS_W'(1);
    b2_idx = pos_d - POS_W'(2);
    b1_en  = 1'b0;
    b2_en  = 1'b0;
    if (mode_in == MODE_WRAP) begin
      b1_en = 1'b1;
      b2_en = 1'b1;
      if (pos_d == '0) begin
        b1_idx = POS_LAST;
        b2_idx = POS_LAST - POS_W'(1);
      end else if (pos_d == POS_W'(1)) begin
        b2_idx = POS_LAST;
      end
    end else if (dir_d == DIR_LEFT) begin
      b1_en = (pos_d >= POS_W'(1));
      b2_en = (pos_d >= POS_W'(2));
    end else begin
      b1_idx = pos_d + POS_W'(1);
      b2_idx = pos_d + POS_W'(2);
      b1_en  = (pos_d < POS_LAST);
      b2_en  = (pos_d < POS_LAST - POS_W'(1));
    end
  end

  // Free-running PWM phase for tail brightness
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) pwm_q <= 3'd0;
    else          pwm_q <= pwm_q + 3'd1;
  end
`endif

  // Frame for the next state: one-hot head, thermometer bar, or converging pair
  always_comb begin
    led_d = '0;
    case (mode_in)
      MODE_BAR: begin
        for (int i = 0; i < N_LEDS; i++) led_d[i] = (POS_W'(i) <= pos_d);
      end
      MODE_CONV: begin
        led_d[pos_d]            = 1'b1;
        led_d[POS_LAST - pos_d] = 1'b1;
      end
      default: begin
        led_d[pos_d] = 1'b1;
`ifdef TRAIL_EN
        if (b1_en && !pwm_q[2])        led_d[b1_idx] = 1'b1;
        if (b2_en && (pwm_q == 3'd0))  led_d[b2_idx] = 1'b1;
`endif
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      dir_q  <= DIR_LEFT;
      mode_q <= MODE_BOUNCE;
      led_q  <= N_LEDS'(1);
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      mode_q <= mode_in;
      led_q  <= led_d;
      tick_q <= tick_d;
    end
  end

  assign LEDR      = led_q;
  assign POS       = pos_q;
  assign STEP_TICK = tick_q;

endmodule
